// File: rtl/wave_channel_gen.sv
// rtl/wave_channel_gen.sv - wave-table APU channel: frequency timer, length counter, volume, CPU-arbitrated wave RAM
// Optional dual-bank wave RAM under WAVE_CHANNEL_GEN_BANK_EN.
module wave_channel_gen #(
  parameter int SAMPLE_W   = 4,
  parameter int WAVE_DEPTH = 32,
  parameter int FREQ_W     = 11,
  parameter int LEN_W      = 8,
  localparam int POS_W     = $clog2(WAVE_DEPTH)
) (
  input  logic                apu_2mhz,
  input  logic                napu_reset,
  input  logic                freq_tick,
  input  logic                len_tick,
  input  logic                dac_en,
  input  logic [FREQ_W-1:0]   freq,
  input  logic                len_load,
  input  logic [LEN_W-1:0]    len_val,
  input  logic                len_en,
  input  logic [1:0]          vol,
  input  logic                trigger,
  input  logic                cpu_wr,
  input  logic                cpu_rd,
  input  logic [POS_W-1:0]    cpu_addr,
  input  logic [SAMPLE_W-1:0] cpu_wdata,
`ifdef WAVE_CHANNEL_GEN_BANK_EN
  input  logic                bank_sel,
  input  logic                bank_dual,
`endif
  output logic [SAMPLE_W-1:0] cpu_rdata,
  output logic                ch_active,
  output logic [POS_W-1:0]    pos,
  output logic [SAMPLE_W-1:0] sample_out
);

`ifdef WAVE_CHANNEL_GEN_BANK_EN
  localparam int RAM_AW = POS_W + 1;
`else
  localparam int RAM_AW = POS_W;
`endif
  localparam int RAM_DEPTH = 1 << RAM_AW;

  logic [SAMPLE_W-1:0] ram [RAM_DEPTH];

  logic [FREQ_W-1:0]   ftimer;
  logic [LEN_W-1:0]    len_cnt;
  logic [SAMPLE_W-1:0] sbuf;
  logic [SAMPLE_W-1:0] scaled;
  logic [POS_W-1:0]    pos_nxt;
  logic [RAM_AW-1:0]   play_idx;
  logic [RAM_AW-1:0]   cpu_idx;
  logic                advance;
  logic                expire;

  // A trigger in the same cycle as a timer wrap wins: pos goes to 0, no latch.
  assign advance = ch_active & freq_tick & (&ftimer) & ~trigger;
  assign expire  = len_tick & len_en & ~len_load & (&len_cnt);
  assign pos_nxt = pos + POS_W'(1);

`ifdef WAVE_CHANNEL_GEN_BANK_EN
  logic play_bank;
  logic bank_nxt;

  assign bank_nxt = (bank_dual && pos == POS_W'(WAVE_DEPTH - 1)) ? ~play_bank : play_bank;
  assign play_idx = {bank_nxt, pos_nxt};
  // The CPU owns the idle bank, so it never has to be redirected to pos.
  assign cpu_idx  = {~play_bank, cpu_addr};

  always_ff @(posedge apu_2mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      play_bank <= 1'b0;
    end else if (trigger) begin
      play_bank <= bank_sel;
    end else if (advance) begin
      play_bank <= bank_nxt;
    end
  end
`else
  assign play_idx = pos_nxt;
  assign cpu_idx  = ch_active ? pos : cpu_addr;
`endif

  always_comb begin
    scaled = '0;
    case (vol)
      2'd1:    scaled = sbuf;
      2'd2:    scaled = sbuf >> 1;
      2'd3:    scaled = sbuf >> 2;
      default: scaled = '0;
    endcase
  end

  always_ff @(posedge apu_2mhz) begin
    if (cpu_wr) begin
      ram[cpu_idx] <= cpu_wdata;
    end
  end

  always_ff @(posedge apu_2mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      ch_active  <= 1'b0;
      pos        <= '0;
      ftimer     <= '0;
      len_cnt    <= '0;
      sbuf       <= '0;
      sample_out <= '0;
      cpu_rdata  <= '0;
    end else begin
      if (!dac_en) begin
        ch_active <= 1'b0;
      end else if (trigger) begin
        ch_active <= 1'b1;
      end else if (expire) begin
        ch_active <= 1'b0;
      end

      if (trigger) begin
        ftimer <= freq;
      end else if (ch_active && freq_tick) begin
        ftimer <= (&ftimer) ? freq : ftimer + FREQ_W'(1);
      end

      if (trigger) begin
        pos <= '0;
      end else if (advance) begin
        pos <= pos_nxt;
      end

      if (advance) begin
        sbuf <= ram[play_idx];
      end

      // Length keeps running while the channel is idle; trigger leaves it alone.
      if (len_load) begin
        len_cnt <= len_val;
      end else if (len_tick && len_en) begin
        len_cnt <= len_cnt + LEN_W'(1);
      end

      sample_out <= ch_active ? scaled : '0;

      // Non-blocking read returns the pre-write word on a simultaneous rd/wr.
      if (cpu_rd) begin
        cpu_rdata <= ram[cpu_idx];
      end
    end
  end

endmodule

// File: tb/tb_wave_channel_gen.sv
// tb/tb_wave_channel_gen.sv - self-checking bench for wave_channel_gen
module tb_wave_channel_gen;

  logic        apu_2mhz   = 1'b0;
  logic        napu_reset = 1'b0;
  logic        freq_tick  = 1'b0;
  logic        len_tick   = 1'b0;
  logic        dac_en     = 1'b0;
  logic [10:0] freq       = '0;
  logic        len_load   = 1'b0;
  logic [7:0]  len_val    = '0;
  logic        len_en     = 1'b0;
  logic [1:0]  vol        = '0;
  logic        trigger    = 1'b0;
  logic        cpu_wr     = 1'b0;
  logic        cpu_rd     = 1'b0;
  logic [4:0]  cpu_addr   = '0;
  logic [3:0]  cpu_wdata  = '0;
  logic [3:0]  cpu_rdata;
  logic        ch_active;
  logic [4:0]  pos;
  logic [3:0]  sample_out;

  wave_channel_gen #(
    .SAMPLE_W(4), .WAVE_DEPTH(32), .FREQ_W(11), .LEN_W(8)
  ) dut (
    .apu_2mhz(apu_2mhz), .napu_reset(napu_reset), .freq_tick(freq_tick),
    .len_tick(len_tick), .dac_en(dac_en), .freq(freq), .len_load(len_load),
    .len_val(len_val), .len_en(len_en), .vol(vol), .trigger(trigger),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .ch_active(ch_active), .pos(pos), .sample_out(sample_out)
  );

  always #5 apu_2mhz = ~apu_2mhz;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: play position derived from ticks elapsed since trigger.
  int ram_m [32];
  bit act_m = 0;
  int t_m   = 0;
  int per_m = 1;
  int pos_m = 0;
  int buf_m = 0;
  int so_m  = 0;
  int rd_m  = 0;
  int len_m = 0;

  typedef struct {
    bit       rd;
    bit       wr;
    bit [4:0] addr;
    bit [3:0] wd;
    int       exp;
  } cpu_vec_t;

  typedef struct {
    bit [1:0] v;
    int       exp;
  } vol_vec_t;

  cpu_vec_t cv [7];
  vol_vec_t vv [4];

  function automatic int scale(input int b, input int v);
    case (v)
      1:       return b;
      2:       return b / 2;
      3:       return b / 4;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  old_pos = pos_m;
    bit  old_act = act_m;
    int  old_buf = buf_m;
    int  addr;
    bit  expd = 0;
    if (len_load) begin
      len_m = int'(len_val);
    end else if (len_tick && len_en) begin
      len_m = (len_m + 1) % 256;
      expd  = (len_m == 0);
    end
    so_m = old_act ? scale(old_buf, int'(vol)) : 0;
    addr = old_act ? old_pos : int'(cpu_addr);
    if (cpu_rd) rd_m = ram_m[addr];
    if (trigger) begin
      t_m   = 0;
      per_m = 2048 - int'(freq);
      pos_m = 0;
    end else if (old_act && freq_tick) begin
      t_m++;
      pos_m = (t_m / per_m) % 32;
      if (t_m % per_m == 0) buf_m = ram_m[pos_m];
    end
    if (cpu_wr) ram_m[addr] = int'(cpu_wdata);
    if (!dac_en)      act_m = 0;
    else if (trigger) act_m = 1;
    else if (expd)    act_m = 0;
  endtask

  task automatic cyc();
    @(posedge apu_2mhz);
    model_edge();
    #1;
    check("ch_active", int'(ch_active), int'(act_m));
    check("pos", int'(pos), pos_m);
    check("sample_out", int'(sample_out), so_m);
    check("cpu_rdata", int'(cpu_rdata), rd_m);
    trigger  = 0;
    len_load = 0;
    len_tick = 0;
    cpu_wr   = 0;
    cpu_rd   = 0;
  endtask

  initial begin
    cv[0] = '{1'b1, 1'b0, 5'd5,  4'd0, 5};
    cv[1] = '{1'b1, 1'b0, 5'd31, 4'd0, 15};
    cv[2] = '{1'b1, 1'b1, 5'd3,  4'd9, 3};
    cv[3] = '{1'b1, 1'b0, 5'd3,  4'd0, 9};
    cv[4] = '{1'b1, 1'b1, 5'd3,  4'd3, 9};
    cv[5] = '{1'b0, 1'b0, 5'd7,  4'd0, 9};
    cv[6] = '{1'b1, 1'b0, 5'd3,  4'd0, 3};
    vv[0] = '{2'd1, 15};
    vv[1] = '{2'd2, 7};
    vv[2] = '{2'd3, 3};
    vv[3] = '{2'd0, 0};
    for (int i = 0; i < 32; i++) ram_m[i] = 0;

    repeat (3) @(posedge apu_2mhz);
    #1;
    check("rst_active", int'(ch_active), 0);
    check("rst_pos", int'(pos), 0);
    check("rst_sample", int'(sample_out), 0);
    check("rst_rdata", int'(cpu_rdata), 0);
    napu_reset = 1;

    for (int i = 0; i < 32; i++) begin
      cpu_wr = 1; cpu_addr = 5'(i); cpu_wdata = 4'(i);
      cyc();
    end

    for (int i = 0; i < 7; i++) begin
      cpu_rd = cv[i].rd; cpu_wr = cv[i].wr; cpu_addr = cv[i].addr; cpu_wdata = cv[i].wd;
      cyc();
      check($sformatf("cpu_vec%0d", i), int'(cpu_rdata), cv[i].exp);
    end

    freq = 11'd2046; dac_en = 1; vol = 2'd1; trigger = 1;
    cyc();
    check("trig_active", int'(ch_active), 1);
    freq_tick = 1;
    for (int n = 1; n <= 64; n++) begin
      cyc();
      if (n == 2) check("first_adv_pos", int'(pos), 1);
      if (n == 4) check("first_sample", int'(sample_out), 1);
      if (n == 62) check("pos_31", int'(pos), 31);
    end
    check("wrap_pos", int'(pos), 0);

    for (int k = 0; k < 100 && pos_m != 15; k++) cyc();
    freq_tick = 0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      vol = vv[i].v;
      cyc();
      check($sformatf("vol%0d", vv[i].v), int'(sample_out), vv[i].exp);
    end

    vol = 2'd1; freq_tick = 1;
    for (int k = 0; k < 100 && pos_m != 5; k++) cyc();
    freq_tick = 0;
    cpu_rd = 1; cpu_addr = 5'd20;
    cyc();
    check("arb_rd", int'(cpu_rdata), 5);
    cpu_wr = 1; cpu_addr = 5'd20; cpu_wdata = 4'hA;
    cyc();
    cpu_rd = 1; cpu_addr = 5'd20;
    cyc();
    check("arb_wr_pos", int'(cpu_rdata), 10);
    dac_en = 0;
    cyc();
    check("dac_off", int'(ch_active), 0);
    trigger = 1;
    cyc();
    check("trig_no_dac", int'(ch_active), 0);
    cpu_rd = 1; cpu_addr = 5'd20;
    cyc();
    check("ram20_kept", int'(cpu_rdata), 4);
    cpu_wr = 1; cpu_addr = 5'd5; cpu_wdata = 4'd5;
    cyc();

    dac_en = 1; len_load = 1; len_val = 8'd250; len_en = 1;
    cyc();
    trigger = 1;
    cyc();
    for (int k = 1; k <= 6; k++) begin
      len_tick = 1;
      cyc();
      if (k == 5) check("len_tick5_active", int'(ch_active), 1);
      if (k == 6) check("len_expired", int'(ch_active), 0);
      cyc();
      if (k == 6) check("len_sample_zero", int'(sample_out), 0);
    end

    len_load = 1; len_val = 8'd250;
    cyc();
    trigger = 1;
    cyc();
    for (int k = 1; k <= 5; k++) begin
      len_tick = 1;
      cyc();
    end
    len_tick = 1; trigger = 1;
    cyc();
    check("collide_active", int'(ch_active), 1);

    len_en = 0;
    freq = 11'(2047 - $urandom_range(0, 3));
    trigger = 1;
    cyc();
    for (int k = 0; k < 500; k++) begin
      freq_tick = 1'($urandom_range(0, 1));
      vol       = 2'($urandom_range(0, 3));
      cpu_rd    = ($urandom_range(0, 3) == 0);
      cpu_wr    = ($urandom_range(0, 7) == 0);
      cpu_addr  = 5'($urandom_range(0, 31));
      cpu_wdata = 4'($urandom_range(0, 15));
      cyc();
    end

    freq_tick = 1; vol = 2'd1;
    repeat (5) cyc();
    #2;
    napu_reset = 0;
    #1;
    check("areset_active", int'(ch_active), 0);
    check("areset_pos", int'(pos), 0);
    check("areset_sample", int'(sample_out), 0);
    check("areset_rdata", int'(cpu_rdata), 0);
    act_m = 0; t_m = 0; pos_m = 0; buf_m = 0; so_m = 0; rd_m = 0; len_m = 0;
    @(posedge apu_2mhz);
    #1;
    napu_reset = 1;
    cpu_rd = 1; cpu_addr = 5'd3;
    cyc();
    check("ram_survives_reset", int'(cpu_rdata), ram_m[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
